// File: rtl/i2s_tx.sv
// Philips I2S transmitter: serializes one W-bit mono sample per frame onto both
// slots, generating BCLK/LRCLK from clk with a single-entry holding register.
module i2s_tx #(
  parameter int W         = 16,
  parameter int HALF_BCLK = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [W-1:0] sample_in,
  input  logic         sample_in_valid,
  output logic         bclk,
  output logic         lrclk,
  output logic         sdata,
  output logic         sample_req,
  output logic         underrun,
  output logic         overrun,
  output logic         hold_full
);

  localparam int PW = $clog2(2 * W);
  localparam int CW = (HALF_BCLK > 1) ? $clog2(HALF_BCLK) : 1;
  localparam logic [PW-1:0] P_LAST   = PW'(2 * W - 1);
  localparam logic [PW-1:0] P_W      = PW'(W);
  localparam logic [CW-1:0] CNT_WRAP = CW'(HALF_BCLK - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] p_q, p_d;
  logic          bclk_q, bclk_d;
  logic          lrclk_q, lrclk_d;
  logic          sdata_q, sdata_d;
  logic          req_q, req_d;
  logic          under_q, under_d;
  logic          over_q, over_d;
  logic          hold_full_q, hold_full_d;
  logic [W-1:0]  hold_q, hold_d;
  logic [W-1:0]  tx_q, tx_d;

  logic [PW-1:0] p_next, q_next;
  logic [W-1:0]  sh_word;
  logic          fall, latch;

  // NOTE: every output of this process gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    cnt_d       = cnt_q;
    p_d         = p_q;
    bclk_d      = bclk_q;
    lrclk_d     = lrclk_q;
    sdata_d     = sdata_q;
    tx_d        = tx_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    req_d       = 1'b0;
    under_d     = 1'b0;
    over_d      = 1'b0;
    fall        = 1'b0;

    p_next  = (p_q == P_LAST) ? '0 : p_q + 1'b1;
    q_next  = (p_next >= P_W) ? p_next - P_W : p_next;
    sh_word = tx_q >> (P_W - q_next);

    if (!enable) begin
      cnt_d   = '0;
      bclk_d  = 1'b0;
      lrclk_d = 1'b0;
      sdata_d = 1'b0;
      p_d     = P_LAST;
    end else if (cnt_q == CNT_WRAP) begin
      cnt_d  = '0;
      bclk_d = ~bclk_q;
      fall   = bclk_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    latch = fall && (p_next == '0);

    // Slot position 0 repeats the previous slot's LSB (the I2S one-bit delay);
    // tx_q still holds the outgoing word when the latch happens.
    if (fall) begin
      p_d     = p_next;
      lrclk_d = (p_next >= P_W);
      sdata_d = (q_next == '0) ? tx_q[0] : sh_word[0];
    end

    if (latch) begin
      req_d       = 1'b1;
      under_d     = ~hold_full_q;
      tx_d        = hold_full_q ? hold_q : '0;
      hold_full_d = 1'b0;
    end

    // A write on the latch cycle refills the register the latch just drained.
    if (sample_in_valid) begin
      hold_d      = sample_in;
      hold_full_d = 1'b1;
      over_d      = hold_full_q & ~latch;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      p_q         <= P_LAST;
      bclk_q      <= 1'b0;
      lrclk_q     <= 1'b0;
      sdata_q     <= 1'b0;
      req_q       <= 1'b0;
      under_q     <= 1'b0;
      over_q      <= 1'b0;
      hold_full_q <= 1'b0;
      hold_q      <= '0;
      tx_q        <= '0;
    end else begin
      cnt_q       <= cnt_d;
      p_q         <= p_d;
      bclk_q      <= bclk_d;
      lrclk_q     <= lrclk_d;
      sdata_q     <= sdata_d;
      req_q       <= req_d;
      under_q     <= under_d;
      over_q      <= over_d;
      hold_full_q <= hold_full_d;
      hold_q      <= hold_d;
      tx_q        <= tx_d;
    end
  end

  assign bclk       = bclk_q;
  assign lrclk      = lrclk_q;
  assign sdata      = sdata_q;
  assign sample_req = req_q;
  assign underrun   = under_q;
  assign overrun    = over_q;
  assign hold_full  = hold_full_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: a table of whole frames checked bit by bit,
// plus hand sequences for reset, overrun, mid-frame reset and enable drop.
module tb_i2s_tx;

  localparam int W         = 16;
  localparam int HALF_BCLK = 4;
  localparam int BCLK_P    = 2 * HALF_BCLK;
  localparam int FRAME     = 4 * W * HALF_BCLK;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [W-1:0] sample_in;
  logic         sample_in_valid;
  logic         bclk, lrclk, sdata, sample_req, underrun, overrun, hold_full;

  int n_vec = 0;
  int n_err = 0;

  i2s_tx #(.W(W), .HALF_BCLK(HALF_BCLK)) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .sample_in       (sample_in),
    .sample_in_valid (sample_in_valid),
    .bclk            (bclk),
    .lrclk           (lrclk),
    .sdata           (sdata),
    .sample_req      (sample_req),
    .underrun        (underrun),
    .overrun         (overrun),
    .hold_full       (hold_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] word;       // word expected in this frame's slots
    logic [W-1:0] prev;       // word of the previous frame (for the p=0 bit)
    logic         exp_under;
    int           wr1_cyc;    // cycle (1-based) the write strobe is sampled, 0 = none
    logic [W-1:0] wr1_val;
    int           wr2_cyc;
    logic [W-1:0] wr2_val;
    int           exp_over;
    logic         exp_full_end;
  } frame_t;

  frame_t frames[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_sd(input int p, input logic [W-1:0] word, input logic [W-1:0] prev);
    int q;
    q = p % W;
    if (q == 0) return (p == 0) ? prev[0] : word[0];
    return word[W - q];
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, " bclk"},       32'(bclk),       32'd0);
    check({tag, " lrclk"},      32'(lrclk),      32'd0);
    check({tag, " sdata"},      32'(sdata),      32'd0);
    check({tag, " sample_req"}, 32'(sample_req), 32'd0);
    check({tag, " underrun"},   32'(underrun),   32'd0);
    check({tag, " overrun"},    32'(overrun),    32'd0);
    check({tag, " hold_full"},  32'(hold_full),  32'd0);
  endtask

  task automatic write_word(input logic [W-1:0] v);
    sample_in       = v;
    sample_in_valid = 1'b1;
    step();
    sample_in_valid = 1'b0;
  endtask

  // Runs exactly one frame; the first bclk fall must land on cycle BCLK_P (p=0).
  task automatic run_frame(input frame_t f);
    int   p = 0;
    int   n_req = 0, n_under = 0, n_over = 0;
    logic prev_bclk;
    prev_bclk = bclk;
    for (int k = 1; k <= FRAME; k++) begin
      sample_in_valid = 1'b0;
      if (k == f.wr1_cyc) begin sample_in = f.wr1_val; sample_in_valid = 1'b1; end
      if (k == f.wr2_cyc) begin sample_in = f.wr2_val; sample_in_valid = 1'b1; end
      step();
      sample_in_valid = 1'b0;
      n_req   += int'(sample_req);
      n_under += int'(underrun);
      n_over  += int'(overrun);
      if (prev_bclk && !bclk && p < 2 * W) begin
        check($sformatf("%s fall time p=%0d", f.name, p), 32'(k), 32'(BCLK_P * (p + 1)));
        check($sformatf("%s lrclk p=%0d", f.name, p), 32'(lrclk), 32'(p >= W));
        check($sformatf("%s sdata p=%0d", f.name, p), 32'(sdata), 32'(exp_sd(p, f.word, f.prev)));
        if (p == 0) begin
          check({f.name, " sample_req at latch"}, 32'(sample_req), 32'd1);
          check({f.name, " underrun at latch"},   32'(underrun),   32'(f.exp_under));
        end
        p++;
      end
      prev_bclk = bclk;
    end
    check({f.name, " fall count"},     32'(p),       32'(2 * W));
    check({f.name, " sample_req cnt"}, 32'(n_req),   32'd1);
    check({f.name, " underrun cnt"},   32'(n_under), 32'(f.exp_under));
    check({f.name, " overrun cnt"},    32'(n_over),  32'(f.exp_over));
    check({f.name, " hold_full end"},  32'(hold_full), 32'(f.exp_full_end));
  endtask

  function automatic frame_t mk(input string name, input logic [W-1:0] word, input logic [W-1:0] prev,
                                input logic exp_under, input int wr1_cyc, input logic [W-1:0] wr1_val,
                                input int wr2_cyc, input logic [W-1:0] wr2_val, input int exp_over,
                                input logic exp_full_end);
    frame_t f;
    f.name = name; f.word = word; f.prev = prev; f.exp_under = exp_under;
    f.wr1_cyc = wr1_cyc; f.wr1_val = wr1_val; f.wr2_cyc = wr2_cyc; f.wr2_val = wr2_val;
    f.exp_over = exp_over; f.exp_full_end = exp_full_end;
    return f;
  endfunction

  initial begin
    //                 name        word     prev     und wr1 val      wr2  val      ovr full
    frames[0] = mk("a5c3",      16'hA5C3, 16'h0000, 0,  0, 16'h0,     0, 16'h0,     0, 0);
    frames[1] = mk("under1",    16'h0000, 16'hA5C3, 1,  0, 16'h0,     0, 16'h0,     0, 0);
    frames[2] = mk("under2",    16'h0000, 16'h0000, 1,  0, 16'h0,     0, 16'h0,     0, 0);
    frames[3] = mk("under3",    16'h0000, 16'h0000, 1,  0, 16'h0,     0, 16'h0,     0, 0);
    frames[4] = mk("ovr_wr",    16'h0000, 16'h0000, 1, 20, 16'h1234, 100, 16'h8001, 1, 1);
    frames[5] = mk("send8001",  16'h8001, 16'h0000, 0, 50, 16'h0F0F,  0, 16'h0,     0, 1);
    frames[6] = mk("latch_wr",  16'h0F0F, 16'h8001, 0,  8, 16'h7000,  0, 16'h0,     0, 1);
    frames[7] = mk("send7000",  16'h7000, 16'h0F0F, 0,  0, 16'h0,     0, 16'h0,     0, 0);

    reset = 1'b1; enable = 1'b0; sample_in = '0; sample_in_valid = 1'b0;
    repeat (5) step();
    reset = 1'b0;
    step();
    check_all_zero("reset");
    repeat (3) step();
    check("idle bclk", 32'(bclk), 32'd0);

    write_word(16'h1234);
    check("idle write hold_full", 32'(hold_full), 32'd1);
    check("idle write bclk",      32'(bclk),      32'd0);
    check("idle write overrun",   32'(overrun),   32'd0);
    write_word(16'hA5C3);
    check("idle rewrite overrun", 32'(overrun), 32'd1);
    step();
    check("overrun one cycle",    32'(overrun), 32'd0);

    enable = 1'b1;
    for (int i = 0; i < 8; i++) run_frame(frames[i]);

    // Reset at p=9 with a sample waiting in the holding register.
    for (int k = 1; k <= BCLK_P * 10; k++) begin
      sample_in_valid = (k == 40);
      sample_in       = 16'h3333;
      step();
    end
    sample_in_valid = 1'b0;
    check("pre-reset hold_full", 32'(hold_full), 32'd1);
    reset = 1'b1;
    step();
    check_all_zero("mid reset");
    step();
    reset = 1'b0;
    run_frame(mk("post_reset", 16'h0000, 16'h0000, 1, 0, 16'h0, 0, 16'h0, 0, 0));

    // Drop enable in the right slot while bclk is high.
    repeat (BCLK_P * 20 + HALF_BCLK) step();
    check("pre-disable bclk",  32'(bclk),  32'd1);
    check("pre-disable lrclk", 32'(lrclk), 32'd1);
    enable = 1'b0;
    step();
    check("disable bclk",  32'(bclk),  32'd0);
    check("disable lrclk", 32'(lrclk), 32'd0);
    check("disable sdata", 32'(sdata), 32'd0);
    write_word(16'h5A5A);
    repeat (10) step();
    check("disabled write hold_full", 32'(hold_full), 32'd1);
    check("disabled bclk stays low",  32'(bclk),      32'd0);
    enable = 1'b1;
    run_frame(mk("reenable", 16'h5A5A, 16'h0000, 0, 0, 16'h0, 0, 16'h0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
# i2s_tx

Serializes the 16-bit Q15 mono samples leaving the FIR filter (`y_out` / `y_out_valid`) into a Philips I2S stream for the output DAC. It is the transmit end of the audio path: the FIR's one-cycle valid strobe writes a single-entry holding register, and the block emits one frame per sample. The same sample goes on both left and right slots. The block generates BCLK and LRCLK from the system clock, flags underrun and overrun, and pulses a frame-boundary request.

## Interface
- `W`, 16: sample width and slot width. Each frame is 2·W BCLK periods.
- `HALF_BCLK`, 4: `clk` cycles per BCLK half-period, ≥2. The BCLK period is 2·HALF_BCLK cycles and the frame is 4·W·HALF_BCLK cycles (256 at defaults).
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  1 runs the serializer; 0 parks it idle.
- `sample_in`  in  W  signed Q15 sample, driven from FIR `y_out`.
- `sample_in_valid`  in  1  one-cycle write strobe, driven from FIR `y_out_valid`.
- `bclk`  out  1  I2S bit clock.
- `lrclk`  out  1  word select: 0 = left slot, 1 = right slot.
- `sdata`  out  1  serial data, MSB first.
- `sample_req`  out  1  one-cycle pulse at each frame latch.
- `underrun`  out  1  one-cycle pulse when a frame latches with the holding register empty.
- `overrun`  out  1  one-cycle pulse when a write overwrites an unsent sample.
- `hold_full`  out  1  holding register occupied.

## Operation
- **Reset:** `bclk`, `lrclk`, `sdata`, `sample_req`, `underrun`, `overrun` and `hold_full` are all 0. The holding register is 0, the divider count is 0, and the bit position p is 2W−1. Reset overrides everything, including mid-frame; the next cycle after reset deasserts is idle.
- **Divider:** while `enable`=1, a counter runs 0..HALF_BCLK−1. At wrap, `bclk` toggles.
- **Falling edge of `bclk`** (the cycle `bclk` goes 1→0): p advances mod 2W. `lrclk` and `sdata` update in that same cycle.
- **`lrclk`:** 0 for p∈[0,W−1]; 1 for p∈[W,2W−1].
- **`sdata`, slot position q = p mod W:**
  - q=0 carries bit 0 (LSB) of the previous slot. This is the I2S one-bit delay.
  - q=1..W−1 carry bits W−1..1 of the current slot.
- **Frame latch** happens on the falling edge where p becomes 0:
  - If `hold_full`=1: the TX word takes the holding value, `hold_full` clears, and `sample_req` pulses.
  - If `hold_full`=0: the TX word becomes 0, and both `underrun` and `sample_req` pulse.
  - The TX word is used for both the left and right slots.
- **Write:** `sample_in_valid`=1 loads the holding register and sets `hold_full`.
  - If `hold_full` was already 1 and no latch occurs in that cycle, `overrun` pulses and the newer sample wins.
- **Simultaneous write and latch:** the latch takes the old holding content (or 0 if empty, with `underrun`). The new sample is then stored, `hold_full` ends at 1, and `overrun` does not pulse.
- **`enable`=0:**
  - Next cycle: `bclk`, `lrclk` and `sdata` go to 0, the divider clears, and p is set to 2W−1.
  - Writes are still accepted.
- **`enable` 0→1:** the first falling edge (p=0, the first latch) occurs 2·HALF_BCLK cycles after the first cycle `enable` is sampled 1.

## Timing
- All outputs are registered. `lrclk` and `sdata` change only together with a `bclk` 1→0 transition, so they are stable HALF_BCLK cycles before the DAC samples on the rising edge.
- **Latency:** a sample held at a frame latch appears as its MSB at p=1, i.e. 2·HALF_BCLK cycles after the latch. Its LSB in the right slot is sent at p=0 of the following frame.
- **Sustained rate:** at most one accepted sample per frame. The producer must write at most once per `sample_req` interval to avoid overrun.
- `sample_req`, `underrun` and `overrun` are never high for more than one consecutive cycle.
- **Defaults:** the BCLK period is 8 cycles and a frame is 256 cycles. The clock and HALF_BCLK are chosen so that the frame rate matches the 16 kHz sample rate.

## Test plan
- **Reset and idle:** hold `reset` for 5 cycles, then release with `enable`=0.
  - All outputs read 0.
  - A write of 0x1234 sets `hold_full`=1 while `bclk` stays 0.
- **Single frame, 0xA5C3:** write 0xA5C3, then raise `enable`.
  - The first `bclk` fall comes at cycle 8 with `sample_req`=1 and `underrun`=0.
  - `sdata` at p=1..15 equals bits 15..1 of 0xA5C3. p=16 carries bit 0 (1), and p=17..31 repeat bits 15..1.
  - `lrclk` is 0 for p 0–15 and 1 for p 16–31.
- **Underrun:** with `enable`=1 and no writes for 3 frames, `sdata` stays 0. `underrun` and `sample_req` each pulse once per 256 cycles.
- **Overrun:** write 0x1234 and then 0x8001 within one frame.
  - One `overrun` pulse on the second write.
  - The next frame transmits 0x8001.
- **Write on the latch cycle:** hold 0x0F0F and write 0x7000 exactly on the p→0 cycle.
  - This frame sends 0x0F0F with no `overrun`.
  - `hold_full`=1 afterwards, and the next frame sends 0x7000.
- **Reset mid-frame:** assert `reset` at p=9.
  - The next cycle shows all reset values with `hold_full`=0.
  - After release, the first frame with no write sends 0 with `underrun`=1.
